// File: rtl/uart_boot_loader_pkg.sv
// Shared constants and loader state encoding for the UART boot loader.
package uart_boot_loader_pkg;

    localparam logic [7:0]  SYNC_BYTE            = 8'hA5;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 104;

    typedef enum logic [2:0] {
        StSync,
        StLenLo,
        StLenHi,
        StData,
        StCsum,
        StDone
    } loader_state_e;

endpackage

// File: rtl/uart_boot_loader_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling timer and stop-bit check.
module uart_rx_8n1
    import uart_boot_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rxd,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_ferr
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop
    } rx_state_e;

    rx_state_e       state_q, state_d;
    logic [1:0]      sync_q, sync_d;
    logic            prev_q, prev_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic            rxs;

    assign rxs = sync_q[1];

    always_comb begin
        state_d = state_q;
        sync_d  = {sync_q[0], uart_rxd};
        prev_d  = rxs;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            RxIdle: begin
                cnt_d = '0;
                // Edge (not level) start so a stuck-low line after a framing error is not re-read.
                if (prev_q && !rxs) begin
                    state_d = RxStart;
                end
            end
            RxStart: begin
                if (cnt_q == CntHalf) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rxs ? RxIdle : RxData;
                end
            end
            RxData: begin
                if (cnt_q == CntFull) begin
                    cnt_d   = '0;
                    shift_d = {rxs, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d = RxStop;
                    end
                end
            end
            RxStop: begin
                if (cnt_q == CntFull) begin
                    cnt_d   = '0;
                    state_d = RxIdle;
                    valid_d = rxs;
                    ferr_d  = !rxs;
                end
            end
            default: state_d = RxIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RxIdle;
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rx_byte  = shift_q;
    assign rx_valid = valid_q;
    assign rx_ferr  = ferr_q;

endmodule

// File: rtl/uart_boot_loader.sv
// Boot loader: receives a length-prefixed, checksummed image over UART into instruction RAM,
// holding the core in reset until the image verifies.
module uart_boot_loader
    import uart_boot_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned MAX_WORDS    = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rxd,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst,
    output logic        load_done,
    output logic        load_error
);

    localparam int unsigned IdxW = $clog2(MAX_WORDS + 1);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ferr;

    uart_rx_8n1 #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk     (clk),
        .rst     (rst),
        .uart_rxd(uart_rxd),
        .rx_byte (rx_byte),
        .rx_valid(rx_valid),
        .rx_ferr (rx_ferr)
    );

    loader_state_e   state_q, state_d;
    logic [15:0]     len_q, len_d;
    logic [7:0]      csum_q, csum_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [1:0]      bcnt_q, bcnt_d;
    logic [23:0]     word_q, word_d;
    logic            we_q, we_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            crst_q, crst_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [15:0]     len_full;

    assign len_full = {rx_byte, len_q[7:0]};

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        csum_d  = csum_q;
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        word_d  = word_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        crst_d  = crst_q;
        done_d  = done_q;
        err_d   = err_q;
        unique case (state_q)
            StSync: begin
                if (rx_valid && rx_byte == SYNC_BYTE) begin
                    err_d   = 1'b0;
                    csum_d  = '0;
                    idx_d   = '0;
                    bcnt_d  = '0;
                    state_d = StLenLo;
                end
            end
            StLenLo: begin
                if (rx_valid) begin
                    len_d[7:0] = rx_byte;
                    state_d    = StLenHi;
                end
            end
            StLenHi: begin
                if (rx_valid) begin
                    len_d = len_full;
                    if (32'(len_full) > MAX_WORDS) begin
                        err_d   = 1'b1;
                        state_d = StSync;
                    end else if (len_full == 16'd0) begin
                        state_d = StCsum;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (rx_valid) begin
                    csum_d = csum_q ^ rx_byte;
                    bcnt_d = bcnt_q + 1'b1;
                    if (bcnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        wdata_d = {rx_byte, word_q};
                        addr_d  = BASE_ADDR + (32'(idx_q) << 2);
                        idx_d   = idx_q + 1'b1;
                        if (32'(idx_q) + 32'd1 == 32'(len_q)) begin
                            state_d = StCsum;
                        end
                    end else begin
                        word_d[8*bcnt_q +: 8] = rx_byte;
                    end
                end
            end
            StCsum: begin
                if (rx_valid) begin
                    if (rx_byte == csum_q) begin
                        done_d  = 1'b1;
                        crst_d  = 1'b0;
                        state_d = StDone;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StSync;
                    end
                end
            end
            StDone: ;
            default: state_d = StSync;
        endcase
        // Framing error aborts any frame in progress; written words stay in RAM.
        if (rx_ferr && state_q != StSync && state_q != StDone) begin
            err_d   = 1'b1;
            state_d = StSync;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StSync;
            len_q   <= '0;
            csum_q  <= '0;
            idx_q   <= '0;
            bcnt_q  <= '0;
            word_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= BASE_ADDR;
            wdata_q <= '0;
            crst_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            csum_q  <= csum_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            word_q  <= word_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            crst_q  <= crst_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign core_rst   = crst_q;
    assign load_done  = done_q;
    assign load_error = err_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: table of frames plus hand-written corner sequences.
module tb_uart_boot_loader;

    localparam int unsigned CLKS = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_rxd = 1'b1;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        load_done;
    logic        load_error;

    uart_boot_loader #(
        .CLKS_PER_BIT(CLKS),
        .BASE_ADDR   (32'h0000_0000),
        .MAX_WORDS   (256)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_rxd  (uart_rxd),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .core_rst  (core_rst),
        .load_done (load_done),
        .load_error(load_error)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int rv_cnt = 0;
    int last_rv = 0;
    int fall_delta = -1;
    logic crst_prev = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
        end
        if (dut.rx_valid) begin
            rv_cnt  = rv_cnt + 1;
            last_rv = cyc;
        end
        if (crst_prev && !core_rst) fall_delta = cyc - last_rv;
        crst_prev = core_rst;
    end

    typedef struct {
        logic        rst_before;
        int          n;
        logic [127:0] frame;
        int          exp_wr;
        logic [31:0] a0, d0, a1, d1;
        logic        done, err, crst;
        logic        chk_fall;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        uart_rxd = 1'b0;
        repeat (CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (CLKS) @(negedge clk);
        end
        uart_rxd = stop;
        repeat (CLKS) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_frame(input int n, input logic [127:0] f);
        for (int i = 0; i < n; i++) send_byte(f[8*(n-1-i) +: 8], 1'b1);
        repeat (4) @(negedge clk);
    endtask

    task automatic clear_mon();
        wr_addr.delete();
        wr_data.delete();
        rv_cnt     = 0;
        fall_delta = -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " imem_we"}, 32'(imem_we), 32'd0);
        check({tag, " imem_addr"}, imem_addr, 32'h0);
        check({tag, " imem_wdata"}, imem_wdata, 32'h0);
        check({tag, " core_rst"}, 32'(core_rst), 32'd1);
        check({tag, " load_done"}, 32'(load_done), 32'd0);
        check({tag, " load_error"}, 32'(load_error), 32'd0);
    endtask

    task automatic check_good_load(input string tag);
        check({tag, " nwr"}, 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            check({tag, " a0"}, wr_addr[0], 32'h0);
            check({tag, " d0"}, wr_data[0], 32'h0000_0013);
            check({tag, " a1"}, wr_addr[1], 32'h4);
            check({tag, " d1"}, wr_data[1], 32'h00A0_0293);
        end
        check({tag, " done"}, 32'(load_done), 32'd1);
        check({tag, " err"}, 32'(load_error), 32'd0);
        check({tag, " core_rst"}, 32'(core_rst), 32'd0);
    endtask

    // Checksum covers the data bytes only: 13^93^02^A0 = 22.
    localparam logic [127:0] GoodFrame = 128'hA5_02_00_13_00_00_00_93_02_A0_00_22;
    localparam logic [127:0] BadFrame  = 128'hA5_02_00_13_00_00_00_93_02_A0_00_21;

    initial begin
        vecs[0] = '{1'b1, 12, GoodFrame, 2, 32'h0, 32'h13, 32'h4, 32'h00A00293, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 12, BadFrame, 2, 32'h0, 32'h13, 32'h4, 32'h00A00293, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 12, GoodFrame, 2, 32'h0, 32'h13, 32'h4, 32'h00A00293, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 5, 128'hA5_01_01_13_00, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 4, 128'hA5_00_00_00, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 12, GoodFrame, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 14, {GoodFrame[111:0], 16'h0}, 0, 32'h0, 32'h0, 32'h0, 32'h0,
                    1'b0, 1'b0, 1'b1, 1'b0};
        // Leading junk bytes before the sync must be ignored.
        vecs[6].frame  = 128'h13_37_A5_02_00_13_00_00_00_93_02_A0_00_22;
        vecs[6].exp_wr = 2;
        vecs[6].a1 = 32'h4; vecs[6].d0 = 32'h13; vecs[6].d1 = 32'h00A00293;
        vecs[6].done = 1'b1; vecs[6].crst = 1'b0; vecs[6].chk_fall = 1'b1;

        do_reset();
        check_reset_vals("reset");

        for (int v = 0; v < 7; v++) begin
            if (vecs[v].rst_before) do_reset();
            clear_mon();
            send_frame(vecs[v].n, vecs[v].frame);
            check($sformatf("v%0d nwr", v), 32'(wr_addr.size()), 32'(vecs[v].exp_wr));
            if (vecs[v].exp_wr == 2 && wr_addr.size() == 2) begin
                check($sformatf("v%0d a0", v), wr_addr[0], vecs[v].a0);
                check($sformatf("v%0d d0", v), wr_data[0], vecs[v].d0);
                check($sformatf("v%0d a1", v), wr_addr[1], vecs[v].a1);
                check($sformatf("v%0d d1", v), wr_data[1], vecs[v].d1);
            end
            check($sformatf("v%0d done", v), 32'(load_done), 32'(vecs[v].done));
            check($sformatf("v%0d err", v), 32'(load_error), 32'(vecs[v].err));
            check($sformatf("v%0d core_rst", v), 32'(core_rst), 32'(vecs[v].crst));
            if (vecs[v].chk_fall)
                check($sformatf("v%0d core_rst fall delay", v), 32'(fall_delta), 32'd1);
        end

        // Bad stop bit on the third data byte.
        do_reset();
        clear_mon();
        send_frame(5, 128'hA5_01_00_13_00);
        send_byte(8'h00, 1'b0);
        repeat (4) @(negedge clk);
        check("ferr err", 32'(load_error), 32'd1);
        check("ferr nwr", 32'(wr_addr.size()), 32'd0);
        check("ferr done", 32'(load_done), 32'd0);
        clear_mon();
        send_frame(12, GoodFrame);
        check_good_load("after ferr");

        // Short low glitch while idle must not produce a byte.
        do_reset();
        clear_mon();
        @(negedge clk);
        uart_rxd = 1'b0;
        repeat (5) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (3 * CLKS) @(negedge clk);
        check("glitch rx_valid", 32'(rv_cnt), 32'd0);
        check("glitch err", 32'(load_error), 32'd0);
        clear_mon();
        send_frame(12, GoodFrame);
        check_good_load("after glitch");

        // Reset asserted in the middle of DATA.
        do_reset();
        clear_mon();
        send_frame(9, 128'hA5_02_00_13_00_00_00_93_02);
        check("mid nwr", 32'(wr_addr.size()), 32'd1);
        check("mid wdata", imem_wdata, 32'h13);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals("in rst");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        clear_mon();
        send_frame(12, GoodFrame);
        check_good_load("after mid rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
